// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory, holds the IF/ID register,
// and absorbs one response in a skid buffer while ID is stalled.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_FETCH | request at PC; a response goes to IF/ID, or to the skid buffer on stall
//   S_BUF   | no request; one fetched instruction waits in the skid buffer
//   S_DRAIN | request at drain_addr kept alive after a redirect; response is dropped
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  input  logic        PC_IFWrite,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        valid_id,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {S_FETCH, S_BUF, S_DRAIN} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] npc_q;
  logic        valid_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_npc_q;
  logic [31:0] drain_addr_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        xfer;

  assign redirect = Z | J | JR;
  assign target   = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
  assign pc_plus4 = pc_q + 32'd4;

  assign imem_req  = !reset && (state_q != S_BUF);
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign xfer      = imem_req && imem_ready;

  assign Instruction_id = instr_q;
  assign NextPC_id      = npc_q;
  assign valid_id       = valid_q;
  assign PC             = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      npc_q        <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_npc_q   <= 32'd0;
      drain_addr_q <= 32'd0;
    end else if (redirect) begin
      pc_q    <= target;
      instr_q <= 32'd0;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      case (state_q)
        // An unanswered request must still complete before memory can accept a new one.
        S_FETCH: if (!xfer) begin
          drain_addr_q <= pc_q;
          state_q      <= S_DRAIN;
        end
        S_BUF:   state_q <= S_FETCH;
        S_DRAIN: if (xfer) state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (xfer) begin
            pc_q <= pc_plus4;
            if (PC_IFWrite) begin
              instr_q <= imem_rdata;
              npc_q   <= pc_plus4;
              valid_q <= 1'b1;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_npc_q   <= pc_plus4;
              state_q      <= S_BUF;
            end
          end else if (PC_IFWrite) begin
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
          end
        end
        S_BUF: begin
          if (PC_IFWrite) begin
            instr_q <= skid_instr_q;
            npc_q   <= skid_npc_q;
            valid_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (PC_IFWrite) begin
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
          end
          if (xfer) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
